md5_msg_loader: RTL and testbench

MD5_MSG_LOADER -- requirements
Module: md5_msg_loader

---
 rtl/md5_msg_loader.sv | 190 +++++++++++++++++++
 tb/tb_md5_msg_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_msg_loader.sv
// md5_msg_loader: assembles a 16-byte message from board switches, one byte
// per press of a load button, and requests a single hash once full.
// Optional key debounce is compiled in with `define MD5_LOADER_DEBOUNCE_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | buffer empty, byte_cnt=0, waiting for the first load event
// LOAD  | 1..15 bytes captured, each load event appends one byte
// FULL  | 16 bytes held, further presses ignored, start=1
// FIRE  | one-cycle action pulse, then back to FULL (fires once per fill)

module md5_msg_loader #(
    parameter int DB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   sw_in,
    input  logic         key_in,
    input  logic         mode,
    input  logic         clr,
    output logic [127:0] data,
    output logic         start,
    output logic         action,
    output logic [4:0]   byte_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2,
        FIRE = 2'd3
    } state_t;

    if (DB_CYCLES < 1) begin : g_param_check
        $error("DB_CYCLES must be at least 1");
    end

    logic         key_s1_q;
    logic         key_s2_q;
    logic [2:0]   warm_q;
    logic         key_filt;
    logic         key_prev_q;
    logic         load_ev;

    state_t       state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         fired_q, fired_d;

    // Two-flop synchronizer plus a warm-up shift register that marks when the
    // synchronizer (and debounce) hold real post-reset samples of key_in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_s1_q <= 1'b0;
            key_s2_q <= 1'b0;
            warm_q   <= 3'b000;
        end else begin
            key_s1_q <= key_in;
            key_s2_q <= key_s1_q;
            warm_q   <= {warm_q[1:0], 1'b1};
        end
    end

`ifdef MD5_LOADER_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_RELOAD = CW'(DB_CYCLES - 1);

    logic          db_q, db_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;

    // Debounce: down-counter reloads while the sample matches the filtered
    // level; the level flips on terminal count after DB_CYCLES differing
    // samples. During warm-up the level is preloaded straight from the
    // synchronizer so a key held through reset never looks like a press.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        if (!warm_q[2]) begin
            db_d     = key_s2_q;
            db_cnt_d = DB_RELOAD;
        end else if (key_s2_q == db_q) begin
            db_cnt_d = DB_RELOAD;
        end else if (db_cnt_q == '0) begin
            db_d     = key_s2_q;
            db_cnt_d = DB_RELOAD;
        end else begin
            db_cnt_d = db_cnt_q - 1'b1;
        end
    end

    // Debounce state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q     <= 1'b0;
            db_cnt_q <= DB_RELOAD;
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign key_filt = db_q;
`else
    assign key_filt = key_s2_q;
`endif

    // Edge detector history; held high until warm-up completes so a key that
    // is already down at reset release cannot produce a rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_prev_q <= 1'b1;
        end else begin
            key_prev_q <= warm_q[2] ? key_filt : 1'b1;
        end
    end

    assign load_ev = key_filt & ~key_prev_q;

    // FSM state, message buffer, byte count and one-shot fire flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            fired_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            fired_q <= fired_d;
        end
    end

    // Next state: clr beats everything (including a coincident load event);
    // mode=0 freezes the loader.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        fired_d = fired_q;
        if (clr) begin
            state_d = IDLE;
            data_d  = '0;
            cnt_d   = '0;
            fired_d = 1'b0;
        end else if (mode) begin
            case (state_q)
                IDLE: begin
                    if (load_ev) begin
                        data_d[127:120] = sw_in;
                        cnt_d           = 5'd1;
                        state_d         = LOAD;
                    end
                end
                LOAD: begin
                    if (load_ev) begin
                        for (int i = 0; i < 16; i++) begin
                            if (cnt_q == 5'(i)) begin
                                data_d[127-8*i -: 8] = sw_in;
                            end
                        end
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd15) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    // Only one hash request per fill; FULL is then terminal.
                    if (!fired_q) begin
                        state_d = FIRE;
                    end
                end
                FIRE: begin
                    fired_d = 1'b1;
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign data     = data_q;
    assign byte_cnt = cnt_q;
    assign start    = (state_q == FULL) || (state_q == FIRE);
    assign action   = (state_q == FIRE) && mode;

endmodule

// File: tb/tb_md5_msg_loader.sv
// Directed self-checking bench for md5_msg_loader.
module tb_md5_msg_loader;

`ifdef MD5_LOADER_DEBOUNCE_EN
    localparam int DBC = 4;
`else
    localparam int DBC = 0;
`endif
    localparam int HOLD = 4 + DBC;
    localparam int REL  = 4 + DBC;

    logic         clk;
    logic         rst;
    logic [7:0]   sw_in;
    logic         key_in;
    logic         mode;
    logic         clr;
    logic [127:0] data;
    logic         start;
    logic         action;
    logic [4:0]   byte_cnt;

    int checks;
    int failures;
    int act_cnt;

    md5_msg_loader #(.DB_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .sw_in(sw_in),
        .key_in(key_in),
        .mode(mode),
        .clr(clr),
        .data(data),
        .start(start),
        .action(action),
        .byte_cnt(byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (action === 1'b1) act_cnt = act_cnt + 1;
    end

    task automatic press(input logic [7:0] b);
        @(negedge clk);
        sw_in  = b;
        key_in = 1'b1;
        repeat (HOLD) @(negedge clk);
        key_in = 1'b0;
        repeat (REL) @(negedge clk);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        act_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        act_cnt = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (data !== 128'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data); end
        checks++; if (byte_cnt !== 5'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", byte_cnt); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start); end
        checks++; if (action !== 1'b0) begin failures++; $display("FAIL reset_action got=%b exp=0", action); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        act_cnt = 0;
    endtask

    task automatic test_latency();
        do_clr();
        mode = 1'b1;
        @(negedge clk);
        sw_in  = 8'h5A;
        key_in = 1'b1;
        repeat (2 + DBC) @(negedge clk);
        checks++; if (byte_cnt !== 5'd0) begin failures++; $display("FAIL latency_early got=%0d exp=0", byte_cnt); end
        @(negedge clk);
        checks++; if (byte_cnt !== 5'd1) begin failures++; $display("FAIL latency_exact got=%0d exp=1", byte_cnt); end
        key_in = 1'b0;
        repeat (REL) @(negedge clk);
        checks++; if (data !== {8'h5A, 120'h0}) begin failures++; $display("FAIL latency_data got=%h exp=5a00..", data); end
    endtask

    task automatic test_fill_sequence();
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            press(8'h61 + 8'(i));
            checks++;
            if (byte_cnt !== 5'(i + 1)) begin
                failures++; $display("FAIL fill_cnt idx=%0d got=%0d exp=%0d", i, byte_cnt, i + 1);
            end
        end
        repeat (5) @(negedge clk);
        checks++; if (data !== 128'h6162636465666768696a6b6c6d6e6f70) begin failures++; $display("FAIL fill_data got=%h exp=6162636465666768696a6b6c6d6e6f70", data); end
        checks++; if (byte_cnt !== 5'd16) begin failures++; $display("FAIL fill_cnt_final got=%0d exp=16", byte_cnt); end
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL fill_start got=%b exp=1", start); end
        checks++; if (act_cnt !== 1) begin failures++; $display("FAIL fill_actions got=%0d exp=1", act_cnt); end
    endtask

    task automatic test_full_no_wrap();
        do_clr();
        mode = 1'b1;
        for (int i = 0; i < 16; i++) press(8'hFF);
        checks++; if (act_cnt !== 1) begin failures++; $display("FAIL nowrap_act16 got=%0d exp=1", act_cnt); end
        press(8'h00);
        repeat (5) @(negedge clk);
        checks++; if (data !== {128{1'b1}}) begin failures++; $display("FAIL nowrap_data got=%h exp=all ones", data); end
        checks++; if (byte_cnt !== 5'd16) begin failures++; $display("FAIL nowrap_cnt got=%0d exp=16", byte_cnt); end
        checks++; if (act_cnt !== 1) begin failures++; $display("FAIL nowrap_actions got=%0d exp=1", act_cnt); end
    endtask

    task automatic test_mode_hold();
        do_clr();
        mode = 1'b0;
        for (int i = 0; i < 5; i++) press(8'h11 + 8'(i));
        checks++; if (byte_cnt !== 5'd0) begin failures++; $display("FAIL mode0_cnt got=%0d exp=0", byte_cnt); end
        checks++; if (data !== 128'h0) begin failures++; $display("FAIL mode0_data got=%h exp=0", data); end
        checks++; if (act_cnt !== 0) begin failures++; $display("FAIL mode0_action got=%0d exp=0", act_cnt); end
        mode = 1'b1;
        press(8'h21);
        press(8'h22);
        mode = 1'b0;
        press(8'h23);
        checks++; if (byte_cnt !== 5'd2) begin failures++; $display("FAIL mode0_freeze_cnt got=%0d exp=2", byte_cnt); end
        checks++; if (data !== {16'h2122, 112'h0}) begin failures++; $display("FAIL mode0_freeze_data got=%h exp=2122..", data); end
        mode = 1'b1;
    endtask

    task automatic test_reset_mid_load();
        do_clr();
        mode = 1'b1;
        for (int i = 0; i < 7; i++) press(8'h61);
        checks++; if (byte_cnt !== 5'd7) begin failures++; $display("FAIL midrst_pre_cnt got=%0d exp=7", byte_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (data !== 128'h0) begin failures++; $display("FAIL midrst_data got=%h exp=0", data); end
        checks++; if (byte_cnt !== 5'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", byte_cnt); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (start !== 1'b0 || action !== 1'b0) begin failures++; $display("FAIL midrst_flags got=%b%b exp=00", start, action); end
        press(8'hA5);
        checks++; if (data !== {8'hA5, 120'h0}) begin failures++; $display("FAIL midrst_first_byte got=%h exp=a500..", data); end
        checks++; if (byte_cnt !== 5'd1) begin failures++; $display("FAIL midrst_restart_cnt got=%0d exp=1", byte_cnt); end
    endtask

    task automatic test_clr_collision();
        do_clr();
        mode = 1'b1;
        press(8'h01);
        press(8'h02);
        press(8'h03);
        checks++; if (byte_cnt !== 5'd3) begin failures++; $display("FAIL coll_pre_cnt got=%0d exp=3", byte_cnt); end
        @(negedge clk);
        sw_in  = 8'h04;
        key_in = 1'b1;
        repeat (2 + DBC) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (byte_cnt !== 5'd0) begin failures++; $display("FAIL coll_cnt got=%0d exp=0", byte_cnt); end
        checks++; if (data !== 128'h0) begin failures++; $display("FAIL coll_data got=%h exp=0", data); end
        key_in = 1'b0;
        repeat (REL + 2) @(negedge clk);
        checks++; if (byte_cnt !== 5'd0) begin failures++; $display("FAIL coll_late_cnt got=%0d exp=0", byte_cnt); end
    endtask

    task automatic test_key_high_at_release();
        @(negedge clk);
        mode   = 1'b1;
        key_in = 1'b1;
        rst    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10 + DBC) @(negedge clk);
        checks++; if (byte_cnt !== 5'd0) begin failures++; $display("FAIL keyhigh_cnt got=%0d exp=0", byte_cnt); end
        key_in = 1'b0;
        repeat (REL) @(negedge clk);
        press(8'h3C);
        checks++; if (byte_cnt !== 5'd1) begin failures++; $display("FAIL keyhigh_next_cnt got=%0d exp=1", byte_cnt); end
        checks++; if (data !== {8'h3C, 120'h0}) begin failures++; $display("FAIL keyhigh_next_data got=%h exp=3c00..", data); end
    endtask

`ifdef MD5_LOADER_DEBOUNCE_EN
    task automatic test_debounce();
        do_clr();
        mode = 1'b1;
        press(8'h10);
        @(negedge clk);
        sw_in  = 8'h20;
        key_in = 1'b1;
        repeat (2) @(negedge clk);
        key_in = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (byte_cnt !== 5'd1) begin failures++; $display("FAIL db_glitch_cnt got=%0d exp=1", byte_cnt); end
        @(negedge clk);
        sw_in  = 8'h30;
        key_in = 1'b1;
        repeat (10) @(negedge clk);
        key_in = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (byte_cnt !== 5'd2) begin failures++; $display("FAIL db_press_cnt got=%0d exp=2", byte_cnt); end
        checks++; if (data !== {16'h1030, 112'h0}) begin failures++; $display("FAIL db_press_data got=%h exp=1030..", data); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        act_cnt  = 0;
        rst      = 1'b1;
        sw_in    = 8'h00;
        key_in   = 1'b0;
        mode     = 1'b0;
        clr      = 1'b0;
        test_reset();
        test_latency();
        test_fill_sequence();
        test_full_no_wrap();
        test_mode_hold();
        test_reset_mid_load();
        test_clr_collision();
        test_key_high_at_release();
`ifdef MD5_LOADER_DEBOUNCE_EN
        test_debounce();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
